// File: rtl/tile_config_writer.sv
// Configuration-bus master: parses TILE/AHI/ALO/LEN frames from a byte
// stream and issues one-cycle write strobes to the per-tile loaders.
module tile_config_writer #(
    parameter int NB_TILES = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8
) (
    input  logic                conf,
    input  logic                reset,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [NB_TILES-1:0] select_tile,
    output logic [ADDR_W-1:0]   address_tile,
    output logic [DATA_W-1:0]   data_tile,
    output logic                busy,
    output logic                frame_done,
    output logic                cfg_done,
    output logic                err
);

    typedef enum logic [2:0] {
        HDR_TILE,
        HDR_AHI,
        HDR_ALO,
        HDR_LEN,
        DATA,
        DONE
    } state_t;

    localparam logic [8:0] NB_LIM = 9'(NB_TILES);

    state_t                state_q, state_d;
    logic [7:0]            tile_q, tile_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic [NB_TILES-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]     aout_q, aout_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  fd_q, fd_d;
    logic                  cfg_q, cfg_d;
    logic                  err_q, err_d;
    logic                  accept;

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sel_d   = '0;
        aout_d  = aout_q;
        dout_d  = dout_q;
        fd_d    = 1'b0;
        err_d   = err_q;
        accept  = s_valid && s_ready_q;

        unique case (state_q)
            HDR_TILE: begin
                if (accept) begin
                    if (s_data == 8'hFF) begin
                        state_d = DONE;
                    end else begin
                        tile_d  = s_data;
                        state_d = HDR_AHI;
                        if ({1'b0, s_data} >= NB_LIM) err_d = 1'b1;
                    end
                end
            end
            HDR_AHI: begin
                if (accept) begin
                    addr_d  = ADDR_W'({s_data[1:0], 8'h00});
                    state_d = HDR_ALO;
                end
            end
            HDR_ALO: begin
                if (accept) begin
                    addr_d  = addr_q | ADDR_W'(s_data);
                    state_d = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (accept) begin
                    // A zero length byte encodes a full 256-byte burst
                    cnt_d   = (s_data == 8'h00) ? 9'd256 : {1'b0, s_data};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    for (int i = 0; i < NB_TILES; i++) begin
                        sel_d[i] = (tile_q == 8'(i));
                    end
                    aout_d = addr_q;
                    dout_d = DATA_W'(s_data);
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = HDR_TILE;
                        fd_d    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HDR_TILE;
            end
        endcase

        s_ready_d = (state_d != DONE);
        busy_d    = (state_d != HDR_TILE && state_d != DONE) || fd_d;
        cfg_d     = cfg_q || (state_q == DONE);
    end

    always_ff @(posedge conf) begin
        if (!reset) begin
            state_q   <= HDR_TILE;
            tile_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            sel_q     <= '0;
            aout_q    <= '0;
            dout_q    <= '0;
            busy_q    <= 1'b0;
            fd_q      <= 1'b0;
            cfg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            sel_q     <= sel_d;
            aout_q    <= aout_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            fd_q      <= fd_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign select_tile  = sel_q;
    assign address_tile = aout_q;
    assign data_tile    = dout_q;
    assign busy         = busy_q;
    assign frame_done   = fd_q;
    assign cfg_done     = cfg_q;
    assign err          = err_q;

endmodule

// File: tb/tb_tile_config_writer.sv
// Randomized bench for tile_config_writer: frames are expanded up front
// into per-byte expected outcomes and compared cycle by cycle.
module tb_tile_config_writer;

    localparam int NT = 4;

    logic       conf = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] select_tile;
    logic [9:0] address_tile;
    logic [7:0] data_tile;
    logic       busy, frame_done, cfg_done, err;

    tile_config_writer #(.NB_TILES(NT), .ADDR_W(10), .DATA_W(8)) dut (
        .conf(conf), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .select_tile(select_tile),
        .address_tile(address_tile), .data_tile(data_tile),
        .busy(busy), .frame_done(frame_done), .cfg_done(cfg_done), .err(err)
    );

    always #5 conf = ~conf;

    typedef struct packed {
        logic       wr;
        logic [3:0] sel;
        logic [9:0] addr;
        logic [7:0] data;
        logic       fd;
        logic       busy;
        logic       hold;
        logic       endm;
        logic       seterr;
    } ann_t;

    logic [7:0] stream[$];
    ann_t       anns[$];
    int         pos = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] e_addr = '0;
    logic [7:0] e_data = '0;
    logic       e_hold = 1'b0;
    logic       e_err  = 1'b0;
    logic       e_done = 1'b0;
    int         e_done_age = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_frame(input int tile, input int addr, input int len,
                             input int first, input int stp, input bit rnd);
        int         n;
        logic [9:0] a10;
        ann_t       h;
        ann_t       d;
        n   = (len == 0) ? 256 : len;
        a10 = addr[9:0];
        h = '0;
        h.busy = 1'b1;
        h.hold = 1'b1;
        h.seterr = (tile >= NT);
        stream.push_back(8'(tile));
        anns.push_back(h);
        h.seterr = 1'b0;
        stream.push_back({6'($urandom), a10[9:8]});
        anns.push_back(h);
        stream.push_back(a10[7:0]);
        anns.push_back(h);
        stream.push_back(8'(len));
        anns.push_back(h);
        for (int i = 0; i < n; i++) begin
            d = '0;
            d.wr   = 1'b1;
            d.sel  = (tile < NT) ? 4'(1 << tile) : 4'b0000;
            d.addr = 10'((addr + i) % 1024);
            d.data = rnd ? 8'($urandom) : 8'(first + i * stp);
            d.fd   = (i == n - 1);
            d.busy = 1'b1;
            d.hold = !d.fd;
            stream.push_back(d.data);
            anns.push_back(d);
        end
    endtask

    task automatic add_end();
        ann_t h;
        h = '0;
        h.endm = 1'b1;
        stream.push_back(8'hFF);
        anns.push_back(h);
    endtask

    task automatic check_cycle(input logic acc, input ann_t a);
        logic [3:0] e_sel;
        logic       e_fd;
        logic       e_busy;
        e_sel  = '0;
        e_fd   = 1'b0;
        e_busy = e_hold;
        if (e_done) e_done_age++;
        if (acc) begin
            if (a.wr) begin
                e_sel  = a.sel;
                e_addr = a.addr;
                e_data = a.data;
                e_fd   = a.fd;
            end
            e_busy = a.busy;
            e_hold = a.hold;
            if (a.seterr) e_err = 1'b1;
            if (a.endm) begin
                e_done = 1'b1;
                e_done_age = 0;
            end
        end
        check("select_tile", 32'(select_tile), 32'(e_sel));
        check("address_tile", 32'(address_tile), 32'(e_addr));
        check("data_tile", 32'(data_tile), 32'(e_data));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("busy", 32'(busy), 32'(e_busy));
        check("err", 32'(err), 32'(e_err));
        check("cfg_done", 32'(cfg_done), 32'(e_done && e_done_age >= 1));
        check("s_ready", 32'(s_ready), 32'(!e_done));
    endtask

    // mode 0: s_valid held high, 1: toggles every cycle, 2: random stalls
    task automatic run_stream(input int mode, input int max_acc);
        int   acc_n;
        int   cyc;
        logic v;
        logic acc;
        ann_t a;
        acc_n = 0;
        cyc   = 0;
        while (pos < stream.size() && acc_n < max_acc && cyc < 5000) begin
            @(negedge conf);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            s_valid = v;
            s_data  = v ? stream[pos] : 8'($urandom);
            @(posedge conf);
            acc = s_valid && s_ready;
            #1;
            a = '0;
            if (acc) begin
                a = anns[pos];
                pos++;
                acc_n++;
            end
            check_cycle(acc, a);
            cyc++;
        end
        if (cyc >= 5000) check("stream_timeout", 32'd1, 32'd0);
        @(negedge conf);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic v);
        logic acc;
        for (int i = 0; i < n; i++) begin
            @(negedge conf);
            s_valid = v;
            s_data  = 8'($urandom);
            @(posedge conf);
            acc = s_valid && s_ready;
            #1;
            check("idle_accept", 32'(acc), 32'd0);
            check_cycle(1'b0, '0);
        end
        @(negedge conf);
        s_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge conf);
        reset   = 1'b0;
        s_valid = 1'($urandom);
        s_data  = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge conf);
            #1;
            check("rst_s_ready", 32'(s_ready), 32'd0);
            check("rst_select", 32'(select_tile), 32'd0);
            check("rst_address", 32'(address_tile), 32'd0);
            check("rst_data", 32'(data_tile), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            check("rst_cfg_done", 32'(cfg_done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        e_addr = '0;
        e_data = '0;
        e_hold = 1'b0;
        e_err  = 1'b0;
        e_done = 1'b0;
        e_done_age = 0;
        pos = stream.size();
        @(negedge conf);
        reset   = 1'b1;
        s_valid = 1'b0;
    endtask

    initial begin
        do_reset(3);

        add_frame(2, 'h123, 1, 'hA5, 0, 1'b0);
        run_stream(0, 100000);
        idle(2, 1'b0);

        add_frame(0, 'h3FE, 4, 'h11, 'h11, 1'b0);
        run_stream(0, 100000);
        idle(2, 1'b0);

        add_frame(0, 'h3FE, 4, 'h11, 'h11, 1'b0);
        run_stream(1, 100000);
        idle(2, 1'b0);

        add_frame(1, 'h2F0, 3, 0, 0, 1'b1);
        add_frame(3, 'h3FD, 5, 0, 0, 1'b1);
        run_stream(0, 100000);

        for (int k = 0; k < 6; k++) begin
            add_frame($urandom_range(0, NT - 1), $urandom_range(0, 1023),
                      $urandom_range(1, 12), 0, 0, 1'b1);
        end
        run_stream(2, 100000);
        idle(2, 1'b0);

        add_frame(7, 'h010, 2, 0, 0, 1'b1);
        add_frame(1, 'h3FF, 3, 0, 0, 1'b1);
        run_stream(0, 100000);
        idle(2, 1'b0);

        add_frame(3, 0, 0, 0, 0, 1'b1);
        run_stream(2, 100000);
        idle(2, 1'b0);

        add_frame(2, 'h100, 4, 'h40, 1, 1'b0);
        run_stream(0, 6);
        do_reset(2);
        add_frame(1, 'h055, 2, 'h60, 3, 1'b0);
        run_stream(0, 100000);
        idle(2, 1'b0);

        add_end();
        run_stream(0, 100000);
        idle(6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
